div_ctrl: RTL

Issue/sequencing controller between the EX stage and the multi-cycle divider `div`. It accepts a DIV/DIVU request from EX, latches and holds the operands, drives the divider's `start_i`/`annul_i`/`signed_div_i` handshake, and raises a pipeline stall request. On completion it returns the quotient and remainder to EX as a one-cycle HI/LO write. It also handles pipeline flush and divide-by-zero.

---
 rtl/div_ctrl_pkg.sv | 34 +++
 rtl/div_ctrl_if.sv | 22 ++
 rtl/div_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider issue controller: state encodings and
// handshake level names used by div_ctrl and the divider it sequences.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DC_IDLE  = 2'b00,
        DC_BUSY  = 2'b01,
        DC_DONE  = 2'b10,
        DC_DRAIN = 2'b11
    } dc_state_e;

    localparam logic RstEnable         = 1'b1;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Cycles spent in DRAIN after an annul so the divider can return to free.
    localparam logic [1:0] DrainCycles = 2'd2;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // The divider packs its result as {remainder, quotient}.
    function automatic hilo_t split_result(input logic [63:0] r);
        hilo_t h;
        h.hi = r[63:32];
        h.lo = r[31:0];
        return h;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Handshake bundle between div_ctrl (master) and the multi-cycle divider (slave).
interface div_ctrl_if;

    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    modport master (
        output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
        input  div_result_i, div_ready_i
    );

    modport slave (
        input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
        output div_result_i, div_ready_i
    );

endinterface

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider: latches operands, drives the
// start/annul handshake, stalls the pipe and returns HI/LO. DIV_ZERO_EXC_EN traps /0.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        div_signed_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    div_ctrl_if.master  dif,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        excp_div0_o
);

    dc_state_e   state_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic        signed_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [1:0]  drain_q;
    logic        div0_q;
    logic        div0_req;
    hilo_t       res;

    assign res = split_result(dif.div_result_i);

`ifdef DIV_ZERO_EXC_EN
    assign div0_req = (reg2_i == 32'd0);
`else
    assign div0_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= DC_IDLE;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            signed_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            drain_q  <= 2'd0;
            div0_q   <= 1'b0;
        end else begin
            case (state_q)
                DC_IDLE: begin
                    if (div_req_i && !flush_i) begin
                        if (div0_req) begin
                            div0_q  <= 1'b1;
                            state_q <= DC_DONE;
                        end else begin
                            op1_q    <= reg1_i;
                            op2_q    <= reg2_i;
                            signed_q <= div_signed_i;
                            div0_q   <= 1'b0;
                            state_q  <= DC_BUSY;
                        end
                    end
                end
                DC_BUSY: begin
                    // Flush has priority: a result arriving this cycle is dropped.
                    if (flush_i) begin
                        drain_q <= DrainCycles - 2'd1;
                        state_q <= DC_DRAIN;
                    end else if (dif.div_ready_i == DivResultReady) begin
                        hi_q    <= res.hi;
                        lo_q    <= res.lo;
                        state_q <= DC_DONE;
                    end
                end
                DC_DONE: begin
                    div0_q  <= 1'b0;
                    state_q <= DC_IDLE;
                end
                DC_DRAIN: begin
                    if (drain_q == 2'd0) begin
                        state_q <= DC_IDLE;
                    end else begin
                        drain_q <= drain_q - 2'd1;
                    end
                end
                default: state_q <= DC_IDLE;
            endcase
        end
    end

    // Start drops combinationally on flush so the annul cycle never restarts the divider.
    assign dif.div_start_o  = (state_q == DC_BUSY && !flush_i) ? DivStart : DivStop;
    assign dif.div_annul_o  = (state_q == DC_BUSY) && flush_i;
    assign dif.div_signed_o = signed_q;
    assign dif.div_op1_o    = op1_q;
    assign dif.div_op2_o    = op2_q;

    always_comb begin
        stallreq_o = 1'b0;
        case (state_q)
            DC_IDLE:  stallreq_o = div_req_i && !flush_i;
            DC_BUSY:  stallreq_o = 1'b1;
            DC_DONE:  stallreq_o = 1'b0;
            DC_DRAIN: stallreq_o = div_req_i;
            default:  stallreq_o = 1'b0;
        endcase
    end

    assign whilo_o = (state_q == DC_DONE) && !flush_i && !div0_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

`ifdef DIV_ZERO_EXC_EN
    assign excp_div0_o = (state_q == DC_DONE) && div0_q;
`else
    assign excp_div0_o = 1'b0;
`endif

endmodule
